// File: rtl/relu_requant_pkg.sv
// Shared constants for relu_requant: element width, vector geometry,
// upstream layer codes and the relu_requant FSM state codes.
package relu_requant_pkg;

  localparam int DATA_LEN_DEF = 16;
  localparam int N_CH         = 32;
  localparam int N_LANE       = 12;
  localparam int N_ELEM       = N_CH * N_LANE;
  localparam int CH_W         = 5;

  // Layer codes as produced by the upstream layer sequencer
  localparam logic [3:0] LAYER_IDLE   = 4'd0;
  localparam logic [3:0] LAYER_CONV1  = 4'd1;
  localparam logic [3:0] LAYER_POOL1  = 4'd2;
  localparam logic [3:0] LAYER_CONV2  = 4'd3;
  localparam logic [3:0] LAYER_POOL2  = 4'd4;
  localparam logic [3:0] LAYER_AFFINE = 4'd5;

  typedef enum logic [1:0] {
    RIDL = 2'd0,
    RPRC = 2'd1,
    RDON = 2'd2
  } relu_state_e;

endpackage

// File: rtl/relu_requant_lane.sv
// One element of the requantiser: ReLU, arithmetic right shift, clip to CLIP.
// bypass_i passes the element through untouched (AFFINE layer).
module requant_lane #(
  parameter int DATA_LEN = 16,
  parameter int SHIFT    = 0,
  parameter int CLIP     = 2**(DATA_LEN-1)-1
) (
  input  logic [DATA_LEN-1:0] x_i,
  input  logic                bypass_i,
  output logic [DATA_LEN-1:0] y_o
);

  localparam logic signed [DATA_LEN-1:0] CLIP_V = DATA_LEN'(CLIP);

  logic signed [DATA_LEN-1:0] relu;
  logic signed [DATA_LEN-1:0] shifted;

  always_comb begin
    relu    = x_i[DATA_LEN-1] ? '0 : $signed(x_i);
    shifted = relu >>> SHIFT;
    if (bypass_i) begin
      y_o = x_i;
    end else if (shifted > CLIP_V) begin
      y_o = CLIP_V;
    end else begin
      y_o = shifted;
    end
  end

endmodule

// File: rtl/relu_requant.sv
// Captures a 32x12 result vector on a rising load edge and requantises one
// 12-element channel per cycle. Optional argmax: RELU_REQUANT_ARGMAX_EN.
module relu_requant
  import relu_requant_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int SHIFT    = 0,
  parameter int CLIP     = 2**(DATA_LEN-1)-1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [3:0]                 cs_layer,
  input  logic [N_ELEM*DATA_LEN-1:0] d,
  output logic                       busy,
  output logic                       valid,
  output logic [N_ELEM*DATA_LEN-1:0] q
`ifdef RELU_REQUANT_ARGMAX_EN
  ,
  output logic [3:0]                 argmax,
  output logic                       argmax_valid
`endif
);

  localparam int VW = N_ELEM * DATA_LEN;

  relu_state_e         state_q, state_d;
  logic                load_q;
  logic                start;
  logic                capture;
  logic                bypass_q;
  logic [CH_W-1:0]     ch_q;
  logic [VW-1:0]       buf_q;
  logic [VW-1:0]       q_q;
  logic [DATA_LEN-1:0] lane_x [N_LANE];
  logic [DATA_LEN-1:0] lane_y [N_LANE];

  assign start = load & ~load_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      RIDL: begin
        if (start) begin
          capture = 1'b1;
          state_d = RPRC;
        end
      end
      RPRC: begin
        if (ch_q == CH_W'(N_CH-1)) begin
          state_d = RDON;
        end
      end
      RDON:    state_d = RIDL;
      default: state_d = RIDL;
    endcase
  end

  assign busy  = (state_q == RPRC);
  assign valid = (state_q == RDON);
  assign q     = q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RIDL;
      load_q   <= 1'b0;
      ch_q     <= '0;
      bypass_q <= 1'b0;
      buf_q    <= '0;
      q_q      <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load;
      if (capture) begin
        buf_q    <= d;
        bypass_q <= (cs_layer == LAYER_AFFINE);
        ch_q     <= '0;
      end else if (state_q == RPRC) begin
        ch_q <= ch_q + 1'b1;
        for (int i = 0; i < N_LANE; i++) begin
          q_q[(int'(ch_q)*N_LANE + i)*DATA_LEN +: DATA_LEN] <= lane_y[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
    assign lane_x[gi] = buf_q[(int'(ch_q)*N_LANE + gi)*DATA_LEN +: DATA_LEN];

    requant_lane #(
      .DATA_LEN (DATA_LEN),
      .SHIFT    (SHIFT),
      .CLIP     (CLIP)
    ) u_lane (
      .x_i      (lane_x[gi]),
      .bypass_i (bypass_q),
      .y_o      (lane_y[gi])
    );
  end

`ifdef RELU_REQUANT_ARGMAX_EN
  // Raw (pre-ReLU) scan of elements 0..9; strict compare keeps the lowest index on ties
  logic [3:0]                 amax_idx_q;
  logic signed [DATA_LEN-1:0] amax_val_q;
  logic signed [DATA_LEN-1:0] amax_cand;

  assign amax_cand = buf_q[int'(ch_q)*DATA_LEN +: DATA_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amax_idx_q <= '0;
      amax_val_q <= '0;
    end else if ((state_q == RPRC) && (ch_q < CH_W'(10))) begin
      if ((ch_q == '0) || (amax_cand > amax_val_q)) begin
        amax_val_q <= amax_cand;
        amax_idx_q <= ch_q[3:0];
      end
    end
  end

  assign argmax       = amax_idx_q;
  assign argmax_valid = valid & bypass_q;
`endif

endmodule

// File: tb/tb_relu_requant.sv
// Self-checking bench for relu_requant: randomized vectors against an
// arithmetic reference model, two instances (default and SHIFT=2/CLIP=100).
module tb_relu_requant;
  import relu_requant_pkg::*;

  localparam int DL = 16;
  localparam int VW = N_ELEM * DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [3:0]    cs_layer;
  logic [VW-1:0] d;
  logic          busy0, valid0, busy1, valid1;
  logic [VW-1:0] q0, q1;
`ifdef RELU_REQUANT_ARGMAX_EN
  logic [3:0]    am0, am1;
  logic          amv0, amv1;
`endif

  always #5 clk = ~clk;

  relu_requant #(.DATA_LEN(DL)) u_dut0 (
    .clk(clk), .rst(rst), .load(load), .cs_layer(cs_layer), .d(d),
    .busy(busy0), .valid(valid0), .q(q0)
`ifdef RELU_REQUANT_ARGMAX_EN
    , .argmax(am0), .argmax_valid(amv0)
`endif
  );

  relu_requant #(.DATA_LEN(DL), .SHIFT(2), .CLIP(100)) u_dut1 (
    .clk(clk), .rst(rst), .load(load), .cs_layer(cs_layer), .d(d),
    .busy(busy1), .valid(valid1), .q(q1)
`ifdef RELU_REQUANT_ARGMAX_EN
    , .argmax(am1), .argmax_valid(amv1)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit hold_load = 1'b0;
  int elem [N_ELEM];
  int exp0 [N_ELEM];
  int exp1 [N_ELEM];

  function automatic int ref_elem(int x, bit byp, int sh, int clip);
    int r;
    if (byp) return x;
    r = (x < 0) ? 0 : x;
    r = r / (1 << sh);
    return (r > clip) ? clip : r;
  endfunction

  function automatic int model_argmax();
    int best = 0;
    for (int i = 1; i < 10; i++) if (elem[i] > elem[best]) best = i;
    return best;
  endfunction

  function automatic int el_at(logic [VW-1:0] v, int i);
    logic signed [DL-1:0] t;
    t = v[i*DL +: DL];
    return int'(t);
  endfunction

  // Index of the first element differing from the expected table, -1 if none
  function automatic int first_bad(logic [VW-1:0] v, bit which);
    for (int i = 0; i < N_ELEM; i++) begin
      if (el_at(v, i) != (which ? exp1[i] : exp0[i])) return i;
    end
    return -1;
  endfunction

  task automatic rand_elems();
    logic signed [DL-1:0] t;
    for (int i = 0; i < N_ELEM; i++) begin
      if ($urandom_range(0, 1) == 1) elem[i] = int'($urandom_range(0, 300)) - 150;
      else begin
        t = DL'($urandom);
        elem[i] = int'(t);
      end
    end
  endtask

  task automatic start_pass(input logic [3:0] layer);
    for (int i = 0; i < N_ELEM; i++) begin
      exp0[i] = ref_elem(elem[i], layer == LAYER_AFFINE, 0, 32767);
      exp1[i] = ref_elem(elem[i], layer == LAYER_AFFINE, 2, 100);
    end
    @(negedge clk);
    for (int i = 0; i < N_ELEM; i++) d[i*DL +: DL] = DL'(elem[i]);
    cs_layer = layer;
    load = 1'b1;
    @(posedge clk);
  endtask

  // Counts negedges after the capture edge until valid (bounded at 100)
  task automatic wait_valid(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold_load) load = 1'b0;
      if (!valid0 && busy0) bcnt++;
    end while (!valid0 && lat < 100);
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; cs_layer = LAYER_IDLE; d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", valid0); end
    checks++; if (q0 !== '0 || q1 !== '0) begin errors++; $display("FAIL reset_q got nonzero required 0"); end
`ifdef RELU_REQUANT_ARGMAX_EN
    checks++; if (am0 !== 4'd0 || amv0 !== 1'b0) begin errors++; $display("FAIL reset_argmax got %0d/%b required 0/0", am0, amv0); end
`endif
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_conv_neg();
    int lat, bcnt, bad;
    for (int i = 0; i < N_ELEM; i++) elem[i] = -5;
    start_pass(LAYER_CONV1);
    wait_valid(lat, bcnt);
    checks++; if (lat != 33) begin errors++; $display("FAIL conv_neg_latency got %0d required 33", lat); end
    checks++; if (bcnt != 32) begin errors++; $display("FAIL conv_neg_busy_cycles got %0d required 32", bcnt); end
    bad = first_bad(q0, 0);
    checks++; if (bad >= 0) begin errors++; $display("FAIL conv_neg_q0 el %0d got %0d required %0d", bad, el_at(q0, bad), exp0[bad]); end
    @(negedge clk);
    checks++; if (valid0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL conv_neg_pulse valid=%b busy=%b required 0/0", valid0, busy0); end
    $display("test_conv_neg latency=%0d busy=%0d", lat, bcnt);
  endtask

  task automatic test_conv_shift();
    int lat, bcnt, bad;
    rand_elems();
    elem[0] = 1000; elem[1] = 13; elem[N_ELEM-1] = -1;
    start_pass(LAYER_CONV2);
    wait_valid(lat, bcnt);
    checks++; if (el_at(q1, 0) != 100) begin errors++; $display("FAIL shift_clip_el0 got %0d required 100", el_at(q1, 0)); end
    checks++; if (el_at(q1, 1) != 3) begin errors++; $display("FAIL shift_el1 got %0d required 3", el_at(q1, 1)); end
    checks++; if (el_at(q1, N_ELEM-1) != 0) begin errors++; $display("FAIL relu_el383 got %0d required 0", el_at(q1, N_ELEM-1)); end
    bad = first_bad(q1, 1);
    checks++; if (bad >= 0) begin errors++; $display("FAIL shift_q1 el %0d got %0d required %0d", bad, el_at(q1, bad), exp1[bad]); end
    bad = first_bad(q0, 0);
    checks++; if (bad >= 0) begin errors++; $display("FAIL noshift_q0 el %0d got %0d required %0d", bad, el_at(q0, bad), exp0[bad]); end
    $display("test_conv_shift q1[0]=%0d q1[1]=%0d", el_at(q1, 0), el_at(q1, 1));
  endtask

  task automatic test_affine();
    int lat, bcnt, bad;
    int head [10] = '{3, 9, 9, -1, -2, -3, -4, -300, -5, -6};
    rand_elems();
    for (int i = 0; i < 10; i++) elem[i] = head[i];
    start_pass(LAYER_AFFINE);
    wait_valid(lat, bcnt);
    checks++; if (el_at(q0, 7) != -300) begin errors++; $display("FAIL affine_el7 got %0d required -300", el_at(q0, 7)); end
    bad = first_bad(q1, 1);
    checks++; if (bad >= 0) begin errors++; $display("FAIL affine_q1 el %0d got %0d required %0d", bad, el_at(q1, bad), exp1[bad]); end
`ifdef RELU_REQUANT_ARGMAX_EN
    checks++; if (am0 !== 4'(model_argmax())) begin errors++; $display("FAIL argmax got %0d required %0d", am0, model_argmax()); end
    checks++; if (amv0 !== 1'b1) begin errors++; $display("FAIL argmax_valid got %b required 1", amv0); end
    @(negedge clk);
    checks++; if (amv0 !== 1'b0) begin errors++; $display("FAIL argmax_valid_pulse got %b required 0", amv0); end
`endif
    $display("test_affine q0[7]=%0d", el_at(q0, 7));
  endtask

  task automatic test_level_hold();
    int pulses, bad;
    rand_elems();
    hold_load = 1'b1;
    start_pass(LAYER_CONV2);
    pulses = 0;
    repeat (80) begin @(negedge clk); if (valid0) pulses++; end
    hold_load = 1'b0;
    load = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL level_hold_pulses got %0d required 1", pulses); end
    rand_elems();
    start_pass(LAYER_CONV1);
    @(negedge clk); load = 1'b0;
    repeat (5) @(negedge clk);
    d = ~d; load = 1'b1;
    @(negedge clk); load = 1'b0;
    pulses = 0;
    repeat (60) begin @(negedge clk); if (valid0) pulses++; end
    checks++; if (pulses != 1) begin errors++; $display("FAIL reedge_in_proc_pulses got %0d required 1", pulses); end
    bad = first_bad(q0, 0);
    checks++; if (bad >= 0) begin errors++; $display("FAIL reedge_q0 el %0d got %0d required %0d", bad, el_at(q0, bad), exp0[bad]); end
    $display("test_level_hold pulses=%0d", pulses);
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, bad;
    rand_elems();
    start_pass(LAYER_CONV1);
    @(negedge clk); load = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0 || valid0 !== 1'b0) begin errors++; $display("FAIL midreset_flags busy=%b valid=%b required 0/0", busy0, valid0); end
    checks++; if (q0 !== '0 || q1 !== '0) begin errors++; $display("FAIL midreset_q got nonzero required 0"); end
    @(negedge clk); rst = 1'b0;
    rand_elems();
    start_pass(LAYER_CONV2);
    wait_valid(lat, bcnt);
    checks++; if (lat != 33) begin errors++; $display("FAIL after_reset_latency got %0d required 33", lat); end
    bad = first_bad(q1, 1);
    checks++; if (bad >= 0) begin errors++; $display("FAIL after_reset_q1 el %0d got %0d required %0d", bad, el_at(q1, bad), exp1[bad]); end
    $display("test_reset_mid latency=%0d", lat);
  endtask

  task automatic test_capture_isolation();
    int lat, bcnt, bad;
    rand_elems();
    start_pass(LAYER_CONV1);
    @(negedge clk);
    load = 1'b0; d = ~d; cs_layer = LAYER_AFFINE;
    wait_valid(lat, bcnt);
    bad = first_bad(q0, 0);
    checks++; if (bad >= 0) begin errors++; $display("FAIL isolation_q0 el %0d got %0d required %0d", bad, el_at(q0, bad), exp0[bad]); end
    bad = first_bad(q1, 1);
    checks++; if (bad >= 0) begin errors++; $display("FAIL isolation_q1 el %0d got %0d required %0d", bad, el_at(q1, bad), exp1[bad]); end
    $display("test_capture_isolation latency=%0d", lat + 1);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, bad;
    logic [3:0] layers [4] = '{LAYER_CONV1, LAYER_AFFINE, LAYER_CONV2, LAYER_POOL1};
    logic [3:0] layer;
    for (int p = 0; p < 6; p++) begin
      rand_elems();
      layer = layers[$urandom_range(0, 3)];
      start_pass(layer);
      wait_valid(lat, bcnt);
      checks++; if (lat != 33) begin errors++; $display("FAIL b2b%0d_latency got %0d required 33", p, lat); end
      bad = first_bad(q0, 0);
      checks++; if (bad >= 0) begin errors++; $display("FAIL b2b%0d_q0 el %0d got %0d required %0d", p, bad, el_at(q0, bad), exp0[bad]); end
      bad = first_bad(q1, 1);
      checks++; if (bad >= 0) begin errors++; $display("FAIL b2b%0d_q1 el %0d got %0d required %0d", p, bad, el_at(q1, bad), exp1[bad]); end
`ifdef RELU_REQUANT_ARGMAX_EN
      checks++; if (amv0 !== (layer == LAYER_AFFINE)) begin errors++; $display("FAIL b2b%0d_argmax_valid got %b required %b", p, amv0, layer == LAYER_AFFINE); end
      checks++; if (am0 !== 4'(model_argmax())) begin errors++; $display("FAIL b2b%0d_argmax got %0d required %0d", p, am0, model_argmax()); end
`endif
      $display("test_back_to_back pass %0d layer=%0d latency=%0d", p, layer, lat);
    end
  endtask

  initial begin
    test_reset();
    test_conv_neg();
    test_conv_shift();
    test_affine();
    test_level_hold();
    test_reset_mid();
    test_capture_isolation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
